mem_ctrl: RTL and testbench
===========================

// Module: mem_ctrl
// PURPOSE
//  Parametrised successor to the multicycle core's unified instruction/data memory.
//  - Depth is configurable; access latency is configurable via wait states.
//  - Every access uses a valid/ready handshake and ends in a one-cycle response.
//  - Loads/stores are lane-correct (byte/halfword chosen by addr[1:0]); misaligned/illegal accesses are flagged.
//  - Sits between the control FSM (IorD/MemWrite/IRWrite) and the register-file writeback path.
// PARAMETERS
//  ADDR_W   12  word-address bits; depth = 2**ADDR_W words of 32 bits
//  LATENCY  2   wait cycles between request accept and array access (0..15)
// PORTS
//  clk              in   1   single clock, rising edge
//  reset            in   1   synchronous, active-high
//  req_valid        in   1   request present; held by requester until accepted
//  req_ready        out  1   1 in IDLE and reset low; accept = req_valid & req_ready
//  IorD_reg         in   1   1: address = AluOut_reg, 0: address = pc_reg
//  IRWrite_reg      in   1   fetch request (priority 1)
//  MemWrite_reg     in   1   store request (priority 2); else load
//  AluControl_reg   in   4   size code: 1000 b, 1001 h, 1010 w, 1100 bu, 1101 hu
//  pc_reg           in   32  fetch address
//  AluOut_reg       in   32  load/store address
//  rsB_reg          in   32  store data (low bits used for b/h)
//  addr_reg         out  32  byte address captured at accept
//  instruction_reg  out  32  fetched instruction
//  data_reg         out  32  load result (extended)
//  resp_valid       out  1   one-cycle pulse: access complete
//  access_err       out  1   valid with resp_valid: misaligned or illegal code
// BEHAVIOUR
//  Reset: state=IDLE; instruction_reg=0, data_reg=0, addr_reg=0, resp_valid=0, access_err=0.
//   Array contents are not cleared.
//  FSM: IDLE --accept--> WAIT (cnt<=LATENCY) --cnt==0--> ACCESS --> IDLE.
//   WAIT decrements cnt each cycle; with LATENCY=0 it lasts one cycle.
//  Capture at accept: op (fetch/store/load by priority), size code, rsB_reg, address.
//   Capture is frozen afterwards; input changes during WAIT are ignored.
//  ACCESS cycle: array read/write at word index addr_reg[ADDR_W+1:2].
//   resp_valid=1 and access_err set on the same edge.
//   Accept-to-resp_valid latency = LATENCY+2 cycles; req_ready returns 1 the cycle after resp_valid.
//  Address bits above ADDR_W+1 are ignored (address wraps modulo depth).
//  Fetch: full word -> instruction_reg; size code ignored; addr[1:0]!=0 -> err.
//  Load b/bu: byte addr[1:0]; h/hu: half addr[1] (addr[0]=1 -> err); w: addr[1:0]!=0 -> err.
//   Sign extension for b/h, zero extension for bu/hu.
//  Store b/h/w: only the addressed byte lanes are written; other lanes preserved.
//  Error (misalign, or load/store code outside the list): no array write.
//   instruction_reg/data_reg unchanged; resp_valid=1, access_err=1.
//  req_valid while req_ready=0 has no effect. Back-to-back requests: next accept at earliest the cycle after resp_valid.
//  Reset during WAIT/ACCESS aborts the pending op: no write occurs and no response is produced.
// CONFIGURATION
//  MEM_STORE_READBACK_EN defined: a successful store also loads the full post-write word into data_reg
//   in the ACCESS cycle (used for store-commit checking).
//  Undefined: stores leave data_reg unchanged.
// TESTING
//  LATENCY=2: sw 0xDEADBEEF @0x10, then lw @0x10 -> resp_valid 4 cycles after each accept; data_reg=0xDEADBEEF, err=0.
//  sb 0x7F @0x13 over 0xDEADBEEF -> word 0x7FADBEEF.
//   Then lb @0x13 -> 0x0000007F; lb @0x12 -> 0xFFFFFFAD; lbu @0x12 -> 0x000000AD.
//  lh @0x11 and lw @0x12 -> access_err=1, data_reg unchanged. sh @0x11 -> no write (lw @0x10 unchanged).
//  Fetch with IorD=0, pc=0x8 -> instruction_reg=mem[2]. IRWrite+MemWrite both high -> fetch only, no write.
//  Assert reset during WAIT of a sw -> no resp_valid; later lw shows old data; req_ready=1 the cycle after reset drops.
//  ADDR_W=4: sw @0x40 aliases @0x00. MEM_STORE_READBACK_EN: sh 0x1234 @0x2 -> data_reg = updated full word.

Source files
------------

// File: rtl/mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_ctrl
// Purpose  : Unified instruction/data memory controller with a valid/ready
//            request handshake, a programmable wait-state latency and a
//            one-cycle response. Lane-correct byte/halfword/word loads and
//            stores, with misaligned or illegal accesses flagged.
// Option   : MEM_STORE_READBACK_EN - a successful store also returns the full
//            post-write word on data_reg.
// Revision : 1.0 - initial release
// ============================================================================
module mem_ctrl #(
  parameter int ADDR_W  = 12,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        IorD_reg,
  input  logic        IRWrite_reg,
  input  logic        MemWrite_reg,
  input  logic [3:0]  AluControl_reg,
  input  logic [31:0] pc_reg,
  input  logic [31:0] AluOut_reg,
  input  logic [31:0] rsB_reg,
  output logic [31:0] addr_reg,
  output logic [31:0] instruction_reg,
  output logic [31:0] data_reg,
  output logic        resp_valid,
  output logic        access_err
);

  localparam int         c_DEPTH = 1 << ADDR_W;
  localparam logic [3:0] c_LAT   = 4'(LATENCY);

  // Size codes shared with the ALU control field
  localparam logic [3:0] c_SZ_B  = 4'b1000;
  localparam logic [3:0] c_SZ_H  = 4'b1001;
  localparam logic [3:0] c_SZ_W  = 4'b1010;
  localparam logic [3:0] c_SZ_BU = 4'b1100;
  localparam logic [3:0] c_SZ_HU = 4'b1101;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_LOAD  = 2'd0,
    OP_STORE = 2'd1,
    OP_FETCH = 2'd2
  } op_t;

  state_t      state_q;
  op_t         op_q;
  logic [3:0]  cnt_q;
  logic [3:0]  size_q;
  logic [31:0] wdata_q;
  logic [31:0] addr_q;
  logic [31:0] instr_q;
  logic [31:0] data_q;
  logic        resp_q;
  logic        err_q;

  logic [31:0] mem_q [c_DEPTH];

  logic [ADDR_W-1:0] w_idx;
  logic [31:0]       w_word;
  logic              w_accept;
  logic              w_is_b;
  logic              w_is_h;
  logic              w_is_w;
  logic              w_err;
  logic [3:0]        w_be;
  logic [31:0]       w_lane;
  logic [31:0]       w_merged;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [31:0]       w_load;
  logic              w_do_write;

  // req_ready stays low while the response pulse is shown so that the next
  // accept lands at earliest one cycle after resp_valid.
  assign req_ready = (state_q == S_IDLE) && !resp_q && !reset;
  assign w_accept  = req_valid && req_ready;

  // Upper address bits are dropped: accesses wrap modulo the array depth.
  assign w_idx  = addr_q[ADDR_W+1:2];
  assign w_word = mem_q[w_idx];

  // Decode size, alignment, lane enables, merged store word and load result
  always_comb begin
    w_is_b = (size_q == c_SZ_B) || (size_q == c_SZ_BU);
    w_is_h = (size_q == c_SZ_H) || (size_q == c_SZ_HU);
    w_is_w = (size_q == c_SZ_W);

    if (op_q == OP_FETCH) begin
      w_err = (addr_q[1:0] != 2'b00);
    end else begin
      w_err = !(w_is_b || w_is_h || w_is_w)
           || (w_is_h && addr_q[0])
           || (w_is_w && (addr_q[1:0] != 2'b00));
    end

    w_be   = 4'b0000;
    w_lane = wdata_q;
    if (w_is_b) begin
      w_be   = 4'b0001 << addr_q[1:0];
      w_lane = {4{wdata_q[7:0]}};
    end else if (w_is_h) begin
      w_be   = addr_q[1] ? 4'b1100 : 4'b0011;
      w_lane = {2{wdata_q[15:0]}};
    end else if (w_is_w) begin
      w_be   = 4'b1111;
      w_lane = wdata_q;
    end

    for (int i = 0; i < 4; i++) begin
      w_merged[8*i +: 8] = w_be[i] ? w_lane[8*i +: 8] : w_word[8*i +: 8];
    end

    w_byte = 8'(w_word >> {addr_q[1:0], 3'b000});
    w_half = addr_q[1] ? w_word[31:16] : w_word[15:0];

    case (size_q)
      c_SZ_B:  w_load = {{24{w_byte[7]}}, w_byte};
      c_SZ_BU: w_load = {24'h000000, w_byte};
      c_SZ_H:  w_load = {{16{w_half[15]}}, w_half};
      c_SZ_HU: w_load = {16'h0000, w_half};
      default: w_load = w_word;
    endcase

    w_do_write = (state_q == S_ACCESS) && (op_q == OP_STORE) && !w_err && !reset;
  end

  // Storage array: not reset, written only by a successful store in ACCESS
  always_ff @(posedge clk) begin
    if (w_do_write) begin
      mem_q[w_idx] <= w_merged;
    end
  end

  // Control FSM with request capture and registered response outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= OP_LOAD;
      cnt_q   <= 4'd0;
      size_q  <= 4'd0;
      wdata_q <= 32'd0;
      addr_q  <= 32'd0;
      instr_q <= 32'd0;
      data_q  <= 32'd0;
      resp_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      resp_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (w_accept) begin
            if (IRWrite_reg) begin
              op_q <= OP_FETCH;
            end else if (MemWrite_reg) begin
              op_q <= OP_STORE;
            end else begin
              op_q <= OP_LOAD;
            end
            size_q  <= AluControl_reg;
            wdata_q <= rsB_reg;
            addr_q  <= IorD_reg ? AluOut_reg : pc_reg;
            cnt_q   <= c_LAT;
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt_q == 4'd0) begin
            state_q <= S_ACCESS;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_ACCESS: begin
          resp_q  <= 1'b1;
          err_q   <= w_err;
          state_q <= S_IDLE;
          if (!w_err) begin
            case (op_q)
              OP_FETCH: instr_q <= w_word;
              OP_LOAD:  data_q  <= w_load;
`ifdef MEM_STORE_READBACK_EN
              OP_STORE: data_q  <= w_merged;
`endif
              default: ;
            endcase
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign addr_reg        = addr_q;
  assign instruction_reg = instr_q;
  assign data_reg        = data_q;
  assign resp_valid      = resp_q;
  assign access_err      = err_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_ctrl
// Purpose  : Self-checking bench for mem_ctrl (ADDR_W=4, LATENCY=2) using a
//            byte-level reference memory model plus directed and random ops.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_ctrl;

  localparam int AW  = 4;
  localparam int LAT = 2;
  localparam int DEP = 1 << AW;

  localparam int OPL = 0;
  localparam int OPS = 1;
  localparam int OPF = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        IorD_reg = 1'b0;
  logic        IRWrite_reg = 1'b0;
  logic        MemWrite_reg = 1'b0;
  logic [3:0]  AluControl_reg = 4'd0;
  logic [31:0] pc_reg = 32'd0;
  logic [31:0] AluOut_reg = 32'd0;
  logic [31:0] rsB_reg = 32'd0;
  logic [31:0] addr_reg;
  logic [31:0] instruction_reg;
  logic [31:0] data_reg;
  logic        resp_valid;
  logic        access_err;

  mem_ctrl #(.ADDR_W(AW), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .IorD_reg(IorD_reg), .IRWrite_reg(IRWrite_reg), .MemWrite_reg(MemWrite_reg),
    .AluControl_reg(AluControl_reg), .pc_reg(pc_reg), .AluOut_reg(AluOut_reg),
    .rsB_reg(rsB_reg), .addr_reg(addr_reg), .instruction_reg(instruction_reg),
    .data_reg(data_reg), .resp_valid(resp_valid), .access_err(access_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [31:0] ref_mem [DEP];
  logic [31:0] exp_instr = 32'd0;
  logic [31:0] exp_data  = 32'd0;
  logic [31:0] exp_addr  = 32'd0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference: byte-granular view of memory, width and signedness from code
  function automatic void ref_access(input int op, input logic [3:0] code,
                                     input logic [31:0] a, input logic [31:0] d,
                                     output bit err);
    int idx, off, nb;
    bit sgn;
    logic [31:0] word, mask, val;
    idx  = int'(a[AW+1:2]);
    off  = int'(a[1:0]);
    word = ref_mem[idx];
    if (op == OPF) begin
      err = (off != 0);
      if (!err) exp_instr = word;
      return;
    end
    case (code)
      4'b1000: begin nb = 1; sgn = 1; end
      4'b1100: begin nb = 1; sgn = 0; end
      4'b1001: begin nb = 2; sgn = 1; end
      4'b1101: begin nb = 2; sgn = 0; end
      4'b1010: begin nb = 4; sgn = 0; end
      default: begin nb = 0; sgn = 0; end
    endcase
    err = (nb == 0) || ((off % nb) != 0);
    if (err) return;
    if (op == OPL) begin
      mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nb)) - 32'h1);
      val  = (word >> (8 * off)) & mask;
      if (sgn && val[8*nb-1]) val = val | ~mask;
      exp_data = val;
    end else begin
      for (int k = 0; k < nb; k++) word[8*(off+k) +: 8] = d[8*k +: 8];
      ref_mem[idx] = word;
`ifdef MEM_STORE_READBACK_EN
      exp_data = word;
`endif
    end
  endfunction

  // One complete transaction: handshake, latency, response and outputs
  task automatic do_req(input int op, input logic [3:0] code, input logic [31:0] a,
                        input logic [31:0] d, input bit use_pc, input bit extra_mw,
                        input string tag);
    int n;
    bit err;
    @(negedge clk);
    req_valid      = 1'b1;
    IorD_reg       = !use_pc;
    pc_reg         = use_pc ? a : $urandom;
    AluOut_reg     = use_pc ? $urandom : a;
    IRWrite_reg    = (op == OPF);
    MemWrite_reg   = (op == OPS) || extra_mw;
    AluControl_reg = code;
    rsB_reg        = d;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check_val({tag, "_rdy"}, 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    // Keep req_valid high with garbage inputs: must be ignored while busy
    IorD_reg       = 1'($urandom);
    IRWrite_reg    = 1'($urandom);
    MemWrite_reg   = 1'($urandom);
    AluControl_reg = 4'($urandom);
    pc_reg         = $urandom;
    AluOut_reg     = $urandom;
    rsB_reg        = $urandom;
    ref_access(op, code, a, d, err);
    exp_addr = a;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!resp_valid && n < 20);
    req_valid = 1'b0;
    check_val({tag, "_lat"}, 32'(n), 32'(LAT + 2));
    check_val({tag, "_err"}, 32'(access_err), 32'(err));
    check_val({tag, "_data"}, data_reg, exp_data);
    check_val({tag, "_instr"}, instruction_reg, exp_instr);
    check_val({tag, "_addr"}, addr_reg, exp_addr);
    check_val({tag, "_busy"}, 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    check_val({tag, "_rdy1"}, 32'(req_ready), 32'd1);
    check_val({tag, "_pulse"}, 32'(resp_valid), 32'd0);
  endtask

  initial begin
    int op;
    bit saw;
    logic [3:0] code;
    logic [31:0] a;
    logic [3:0] codes [6];
    codes = '{4'b1000, 4'b1001, 4'b1010, 4'b1100, 4'b1101, 4'b0110};

    repeat (3) @(posedge clk);
    #1;
    check_val("rst_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_val("rst_ready1", 32'(req_ready), 32'd1);
    check_val("rst_instr", instruction_reg, 32'd0);
    check_val("rst_data", data_reg, 32'd0);
    check_val("rst_addr", addr_reg, 32'd0);
    check_val("rst_resp", 32'(resp_valid), 32'd0);
    check_val("rst_err", 32'(access_err), 32'd0);

    // Fill the whole array so the model knows every word
    for (int i = 0; i < DEP; i++) do_req(OPS, 4'b1010, 32'(4 * i), $urandom, 0, 0, "init");

    do_req(OPS, 4'b1010, 32'h10, 32'hDEADBEEF, 0, 0, "sw10");
    do_req(OPL, 4'b1010, 32'h10, 32'h0, 0, 0, "lw10");
    check_val("spec_lw10", data_reg, 32'hDEADBEEF);
    do_req(OPS, 4'b1000, 32'h13, 32'h0000007F, 0, 0, "sb13");
    do_req(OPL, 4'b1010, 32'h10, 32'h0, 0, 0, "lw10b");
    check_val("spec_sb", data_reg, 32'h7FADBEEF);
    do_req(OPL, 4'b1000, 32'h13, 32'h0, 0, 0, "lb13");
    check_val("spec_lb13", data_reg, 32'h0000007F);
    do_req(OPL, 4'b1000, 32'h12, 32'h0, 0, 0, "lb12");
    check_val("spec_lb12", data_reg, 32'hFFFFFFAD);
    do_req(OPL, 4'b1100, 32'h12, 32'h0, 0, 0, "lbu12");
    check_val("spec_lbu12", data_reg, 32'h000000AD);
    do_req(OPL, 4'b1001, 32'h11, 32'h0, 0, 0, "lh11");
    do_req(OPL, 4'b1010, 32'h12, 32'h0, 0, 0, "lw12");
    do_req(OPS, 4'b1001, 32'h11, 32'h5555AAAA, 0, 0, "sh11");
    do_req(OPL, 4'b1010, 32'h10, 32'h0, 0, 0, "lw10c");
    check_val("spec_sh11", data_reg, 32'h7FADBEEF);
    do_req(OPL, 4'b0111, 32'h10, 32'h0, 0, 0, "badcode");
    do_req(OPF, 4'b0000, 32'h8, 32'h0, 1, 0, "fetch8");
    do_req(OPF, 4'b1010, 32'h8, 32'hCAFEF00D, 1, 1, "fetchmw");
    do_req(OPL, 4'b1010, 32'h8, 32'h0, 0, 0, "lw8");
    do_req(OPF, 4'b0000, 32'h6, 32'h0, 0, 0, "fetchmis");
    do_req(OPS, 4'b1010, 32'h40, 32'h0BADF00D, 0, 0, "sw40");
    do_req(OPL, 4'b1010, 32'h00, 32'h0, 0, 0, "lw00");
    check_val("spec_alias", data_reg, 32'h0BADF00D);
    do_req(OPS, 4'b1001, 32'h2, 32'h00001234, 0, 0, "sh02");
    do_req(OPL, 4'b1101, 32'h2, 32'h0, 0, 0, "lhu02");
    check_val("spec_lhu02", data_reg, 32'h00001234);

    // Reset during WAIT of a store aborts it
    @(negedge clk);
    req_valid = 1'b1; IorD_reg = 1'b1; IRWrite_reg = 1'b0; MemWrite_reg = 1'b1;
    AluControl_reg = 4'b1010; AluOut_reg = 32'h10; rsB_reg = 32'h12345678;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_data = 32'd0; exp_instr = 32'd0; exp_addr = 32'd0;
    #1;
    check_val("abort_rdy", 32'(req_ready), 32'd1);
    check_val("abort_data", data_reg, 32'd0);
    saw = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (resp_valid) saw = 1'b1;
    end
    check_val("abort_resp", 32'(saw), 32'd0);
    do_req(OPL, 4'b1010, 32'h10, 32'h0, 0, 0, "lwafter");
    check_val("spec_abort", data_reg, 32'h7FADBEEF);

    // Random mix of fetches, loads and stores against the model
    for (int t = 0; t < 80; t++) begin
      op   = int'($urandom_range(0, 2));
      code = codes[$urandom_range(0, 5)];
      a    = $urandom;
      if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
      do_req(op, code, a, $urandom, bit'($urandom), 0, "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got 0x%08h expected 0x%08h", 32'd0, 32'd1);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
